mem_requester: RTL and testbench

MEM_REQUESTER -- requirements
Module: mem_requester

---
 rtl/mem_requester.sv | 156 +++++++++++++++
 tb/tb_mem_requester.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_requester.sv
// mem_requester: turns a single CPU load/store request into a word-addressed
// memory access. Loads wait for the adapter's busy->idle handshake (with a
// timeout), stores issue one byte-enabled write cycle. Misaligned requests
// finish immediately with err and never touch the memory.
module mem_requester #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        stall,
  output logic        mem_re,
  output logic [3:0]  mem_we,
  output logic [6:0]  mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_dready
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

  state_t      state, next_state;
  logic [8:0]  a_addr;
  logic [1:0]  a_size;
  logic        a_sext;
  logic [31:0] a_wdata;
  logic        seen_busy;
  logic [CW-1:0] cnt;
  logic        err_flag;

  logic        misalign;
  logic        rd_ok;
  logic        rd_timeout;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_value;
  logic [3:0]  store_be;
  logic [31:0] store_data;

  // Misalignment is judged on the live request inputs, i.e. at acceptance.
  assign misalign = (size == 2'b01) ? addr[0] : ((size[1] == 1'b1) && (addr[1:0] != 2'b00));

  // A load completes once the adapter was seen busy and has gone idle again;
  // completion wins over a timeout landing on the same cycle.
  assign rd_ok      = (state == RD_WAIT) && !mem_dready && seen_busy;
  assign rd_timeout = (state == RD_WAIT) && !rd_ok && (cnt == CW'(TIMEOUT - 1));

  assign byte_sel = mem_dout[{a_addr[1:0], 3'b000} +: 8];
  assign half_sel = mem_dout[{a_addr[1], 4'b0000} +: 16];

  // Little-endian lane extraction plus zero/sign extension of the load result.
  always_comb begin
    load_value = mem_dout;
    case (a_size)
      2'b00:   load_value = a_sext ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      2'b01:   load_value = a_sext ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      default: load_value = mem_dout;
    endcase
  end

  // Store byte enables and lane-replicated store data.
  always_comb begin
    store_be   = 4'b1111;
    store_data = a_wdata;
    case (a_size)
      2'b00: begin
        store_be   = 4'b0001 << a_addr[1:0];
        store_data = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        store_be   = 4'b0011 << a_addr[1:0];
        store_data = {2{a_wdata[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = a_wdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (misalign) next_state = DONE;
          else if (wr)  next_state = WR;
          else          next_state = RD_WAIT;
        end
      end
      RD_WAIT: if (rd_ok || rd_timeout) next_state = DONE;
      WR:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs; all fall to zero as soon as reset forces IDLE.
  always_comb begin
    mem_re   = (state == RD_WAIT);
    mem_we   = (state == WR) ? store_be : 4'b0000;
    done     = (state == DONE);
    err      = (state == DONE) && err_flag;
    stall    = (state != IDLE);
    mem_addr = a_addr[8:2];
    mem_din  = store_data;
  end

  // Request latch, read-wait bookkeeping and the load result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_addr    <= '0;
      a_size    <= '0;
      a_sext    <= 1'b0;
      a_wdata   <= '0;
      seen_busy <= 1'b0;
      cnt       <= '0;
      err_flag  <= 1'b0;
      rdata     <= '0;
    end else begin
      if (state == IDLE && req) begin
        a_addr    <= addr;
        a_size    <= size;
        a_sext    <= sext;
        a_wdata   <= wdata;
        seen_busy <= 1'b0;
        cnt       <= '0;
        err_flag  <= misalign;
      end
      if (state == RD_WAIT) begin
        cnt <= cnt + CW'(1);
        if (mem_dready) seen_busy <= 1'b1;
        if (rd_ok)      rdata     <= load_value;
        if (rd_timeout) err_flag  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Randomized bench for mem_requester: a behavioural model computes the
// expected latency, strobes, store lanes and load results for each access.
module tb_mem_requester;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sext;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        stall;
  logic        mem_re;
  logic [3:0]  mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_dready;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = '0;

  mem_requester #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .stall(stall), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_dready(mem_dready)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_misaligned(input logic [1:0] sz, input logic [8:0] a);
    int off = int'(a[1:0]);
    if (sz == 2'b01) return (off % 2) != 0;
    if (sz >= 2'b10) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                           input bit se, input logic [8:0] a);
    int off = int'(a[1:0]);
    longint v;
    if (sz == 2'b00) begin
      v = (longint'(word) / (longint'(1) << (8 * off))) % 256;
      if (se && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (longint'(word) / (longint'(1) << (16 * (off / 2)))) % 65536;
      if (se && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = longint'(word);
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [8:0] a);
    int off = int'(a[1:0]);
    int r;
    if (sz == 2'b00)      r = 1 << off;
    else if (sz == 2'b01) r = 3 << off;
    else                  r = 15;
    return r[3:0];
  endfunction

  function automatic logic [31:0] ref_din(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return (d % 256) * 32'h0101_0101;
    if (sz == 2'b01) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // ---------------- driver ----------------
  // Issues one access from IDLE (called #1 after a rising edge), plays the
  // adapter (busy for 'busy' cycles then idle, or stuck idle), and checks
  // every strobe cycle, the completion latency and the result.
  task automatic run_access(input string tag, input bit w, input logic [1:0] sz, input bit se,
                            input logic [8:0] a, input logic [31:0] wd, input logic [31:0] dout,
                            input int busy, input bit stuck);
    bit   mis      = ref_misaligned(sz, a);
    bit   rd_good  = !stuck && busy >= 1 && (busy + 1) <= TIMEOUT;
    int   rd_cyc   = rd_good ? busy + 1 : TIMEOUT;
    int   exp_n;
    bit   exp_err;
    int   n = 0, cyc = 0, re_seen = 0, we_seen = 0;

    if (mis)    begin exp_n = 0;      exp_err = 1'b1;     end
    else if (w) begin exp_n = 1;      exp_err = 1'b0;     end
    else        begin exp_n = rd_cyc; exp_err = !rd_good; end
    if (!mis && !w && rd_good) model_rdata = ref_load(dout, sz, se, a);
    exp_q.push_back(model_rdata);

    req = 1'b1; wr = w; size = sz; sext = se; addr = a; wdata = wd;
    mem_dout = dout; mem_dready = 1'b0;
    @(posedge clk); #1;
    // Request is now latched: scramble the request fields, keep req held.
    addr = 9'($urandom); wdata = $urandom; size = 2'($urandom); sext = 1'($urandom);
    check({tag, "_stall"}, 32'(stall), 32'd1);
    while (done !== 1'b1 && n < 40) begin
      if (mem_re === 1'b1) begin
        if (re_seen == 0) check({tag, "_rd_addr"}, 32'(mem_addr), 32'(a[8:2]));
        re_seen++;
        mem_dready = !stuck && (cyc < busy);
        cyc++;
      end
      if (mem_we !== 4'b0000) begin
        we_seen++;
        check({tag, "_we"},      32'(mem_we),   32'(ref_be(sz, a)));
        check({tag, "_din"},     mem_din,       ref_din(sz, wd));
        check({tag, "_wr_addr"}, 32'(mem_addr), 32'(a[8:2]));
      end
      @(posedge clk); #1;
      n++;
    end
    mem_dready = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_n));
    check({tag, "_re_cycles"}, 32'(re_seen), (mis || w) ? 32'd0 : 32'(rd_cyc));
    check({tag, "_we_cycles"}, 32'(we_seen), (!mis && w) ? 32'd1 : 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"},  32'(err),  32'(exp_err));
    check({tag, "_rdata"}, rdata, exp_q.pop_front());
    req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_stall_end"},  32'(stall), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0; addr = '0;
    wdata = '0; mem_dout = '0; mem_dready = 1'b0;
    @(posedge clk); #1;
    check("rst_state", {rdata[31:0]}, 32'd0);
    check("rst_ctrl", {21'b0, done, err, stall, mem_re, mem_we, 4'b0},
          32'd0);
    check("rst_addr_din", {25'b0, mem_addr} | mem_din, 32'd0);
    rst = 1'b0;

    // Directed cases.
    run_access("byte_ld_off3", 1'b0, 2'b00, 1'b1, 9'h007, 32'h0, 32'h80FF_1234, 2, 1'b0);
    check("byte_ld_off3_val", rdata, 32'hFFFF_FF80);
    run_access("byte_ld_off2", 1'b0, 2'b00, 1'b1, 9'h006, 32'h0, 32'h80FF_1234, 2, 1'b0);
    run_access("half_st",      1'b1, 2'b01, 1'b0, 9'h00A, 32'h0000_BEEF, 32'h0, 0, 1'b0);
    run_access("word_misal",   1'b0, 2'b10, 1'b0, 9'h003, 32'h0, 32'h1111_2222, 2, 1'b0);
    run_access("half_misal_st",1'b1, 2'b01, 1'b0, 9'h005, 32'h1234_5678, 32'h0, 0, 1'b0);
    run_access("timeout",      1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
    run_access("busy_14",      1'b0, 2'b11, 1'b0, 9'h014, 32'h0, 32'hCAFE_F00D, 14, 1'b0);
    run_access("busy_15",      1'b0, 2'b10, 1'b0, 9'h018, 32'h0, 32'h0BAD_0BAD, 15, 1'b0);
    run_access("half_ld_sext", 1'b0, 2'b01, 1'b1, 9'h0F2, 32'h0, 32'h9ABC_1234, 1, 1'b0);

    // Reset in the middle of a read wait.
    req = 1'b1; wr = 1'b0; size = 2'b10; sext = 1'b0; addr = 9'h020; mem_dready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_re", 32'(mem_re), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_re",    32'(mem_re), 32'd0);
    check("mid_rst_stall", 32'(stall),  32'd0);
    check("mid_rst_rdata", rdata,       32'd0);
    model_rdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_access("post_rst_ld", 1'b0, 2'b00, 1'b0, 9'h000, 32'h0, 32'h0000_00A5, 2, 1'b0);
    check("post_rst_val", rdata, 32'h0000_00A5);

    // Randomized accesses.
    for (int i = 0; i < 60; i++) begin
      run_access($sformatf("rand%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
                 9'($urandom), $urandom, $urandom, int'($urandom_range(0, 17)),
                 ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
